// File: rtl/alu_share_pkg.sv
// Shared definitions for the two-requester ALU arbiter: opcodes, FSM states, default widths.
package alu_share_pkg;

  localparam int W_DEFAULT   = 4;
  localparam int OPW_DEFAULT = 4;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_NOTA = 4'd4;
  localparam logic [3:0] OP_NAND = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
  localparam logic [3:0] OP_XOR  = 4'd8;
  localparam logic [3:0] OP_XNOR = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_share_core.sv
// Combinational 4-bit ALU: result plus carry/borrow, zero and negative flags.
module alu_share_core
  import alu_share_pkg::*;
#(
  parameter int W   = W_DEFAULT,
  parameter int OPW = OPW_DEFAULT
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [OPW-1:0] op,
  output logic [W-1:0]   y,
  output logic           c,
  output logic           z,
  output logic           n
);

  logic [W:0] sum;
  logic       borrow;
  logic       shift_oob;

  assign sum       = {1'b0, a} + {1'b0, b};
  assign borrow    = (b > a);
  assign shift_oob = (b >= W'(W));

  always_comb begin
    y = '0;
    c = 1'b0;
    n = 1'b0;
    case (op)
      OP_ADD: begin
        y = sum[W-1:0];
        c = sum[W];
      end
      OP_SUB: begin
        y = a - b;
        c = borrow;
        n = borrow;
      end
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NOTA: y = ~a;
      OP_NAND: y = ~(a & b);
      OP_SHL:  y = shift_oob ? '0 : (a << b);
      OP_SHR:  y = shift_oob ? '0 : (a >> b);
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      default: y = '0;
    endcase
  end

  // Undefined opcodes never report zero even though their result is 0.
  assign z = (op <= OP_XNOR) && (y == '0);

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU between two valid/ready requesters.
// Optional flag registers are enabled with `define ALU_ARB_FLAGS_EN.
module alu_share_arbiter
  import alu_share_pkg::*;
#(
  parameter int W   = W_DEFAULT,
  parameter int OPW = OPW_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [W-1:0]   req0_a,
  input  logic [W-1:0]   req0_b,
  input  logic [OPW-1:0] req0_op,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [W-1:0]   req1_a,
  input  logic [W-1:0]   req1_b,
  input  logic [OPW-1:0] req1_op,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [W-1:0]   rsp_y,
  output logic           rsp_c,
  output logic           rsp_z,
  output logic           rsp_n,
  output logic           busy
);

  state_t         state_q, state_d;
  logic           last_grant_q;
  logic           grant_id;
  logic           any_valid;
  logic           accept;
  logic [W-1:0]   lat_a, lat_b;
  logic [OPW-1:0] lat_op;
  logic           lat_id;
  logic [W-1:0]   alu_y;
  logic           alu_c, alu_z, alu_n;

  // On contention the requester that did not win last time is granted.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    grant_id  = 1'b0;
    if (req0_valid && req1_valid) grant_id = ~last_grant_q;
    else if (req1_valid)          grant_id = 1'b1;
  end

  assign accept     = (state_q == IDLE) && any_valid;
  assign req0_ready = accept && !grant_id;
  assign req1_ready = accept && grant_id;
  assign busy       = (state_q != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      lat_a        <= '0;
      lat_b        <= '0;
      lat_op       <= '0;
      lat_id       <= 1'b0;
    end else if (accept) begin
      last_grant_q <= grant_id;
      lat_a        <= grant_id ? req1_a  : req0_a;
      lat_b        <= grant_id ? req1_b  : req0_b;
      lat_op       <= grant_id ? req1_op : req0_op;
      lat_id       <= grant_id;
    end
  end

  alu_share_core #(.W(W), .OPW(OPW)) u_core (
    .a  (lat_a),
    .b  (lat_b),
    .op (lat_op),
    .y  (alu_y),
    .c  (alu_c),
    .z  (alu_z),
    .n  (alu_n)
  );

  // Response registers load only in EXEC, so they hold while back-pressured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_y     <= '0;
    end else if (state_q == EXEC) begin
      rsp_valid <= 1'b1;
      rsp_id    <= lat_id;
      rsp_y     <= alu_y;
    end else if (state_q == RESP && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

`ifdef ALU_ARB_FLAGS_EN
  logic flag_c_q, flag_z_q, flag_n_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_c_q <= 1'b0;
      flag_z_q <= 1'b0;
      flag_n_q <= 1'b0;
    end else if (state_q == EXEC) begin
      flag_c_q <= alu_c;
      flag_z_q <= alu_z;
      flag_n_q <= alu_n;
    end
  end

  assign rsp_c = flag_c_q;
  assign rsp_z = flag_z_q;
  assign rsp_n = flag_n_q;
`else
  logic flags_unused;

  assign flags_unused = alu_c ^ alu_z ^ alu_n;
  assign rsp_c = 1'b0;
  assign rsp_z = 1'b0;
  assign rsp_n = 1'b0;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: ALU results, flags, arbitration, back-pressure, reset.
module tb_alu_share_arbiter;

`ifdef ALU_ARB_FLAGS_EN
  localparam logic FLAGS_EN = 1'b1;
`else
  localparam logic FLAGS_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [3:0] req0_a, req0_b, req0_op;
  logic [3:0] req1_a, req1_b, req1_op;
  logic       rsp_valid, rsp_ready, rsp_id;
  logic [3:0] rsp_y;
  logic       rsp_c, rsp_z, rsp_n;
  logic       busy;

  int vectors;
  int miscompares;

  alu_share_arbiter #(.W(4), .OPW(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_y      (rsp_y),
    .rsp_c      (rsp_c),
    .rsp_z      (rsp_z),
    .rsp_n      (rsp_n),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic v0, input logic [3:0] a0, input logic [3:0] b0,
                               input logic [3:0] op0, input logic v1, input logic [3:0] a1,
                               input logic [3:0] b1, input logic [3:0] op1, input logic rr);
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
    rsp_ready  = rr;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // One isolated operation on a single port, response consumed immediately.
  task automatic runOp(input logic port, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] op, input logic [3:0] ey, input logic ec,
                       input logic ez, input logic en, input string tag);
    if (port == 1'b0) applyStimulus(1'b1, a, b, op, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1);
    else              applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 1'b1, a, b, op, 1'b1);
    #1;
    checkOutput({tag, " ready"}, 8'(port ? req1_ready : req0_ready), 8'd1);
    @(negedge clk);
    applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1);
    checkOutput({tag, " exec busy"}, 8'(busy), 8'd1);
    checkOutput({tag, " exec rsp_valid"}, 8'(rsp_valid), 8'd0);
    @(negedge clk);
    checkOutput({tag, " rsp_valid"}, 8'(rsp_valid), 8'd1);
    checkOutput({tag, " rsp_id"}, 8'(rsp_id), 8'(port));
    checkOutput({tag, " rsp_y"}, 8'(rsp_y), 8'(ey));
    checkOutput({tag, " rsp_c"}, 8'(rsp_c), 8'(ec & FLAGS_EN));
    checkOutput({tag, " rsp_z"}, 8'(rsp_z), 8'(ez & FLAGS_EN));
    checkOutput({tag, " rsp_n"}, 8'(rsp_n), 8'(en & FLAGS_EN));
    @(negedge clk);
    checkOutput({tag, " idle rsp_valid"}, 8'(rsp_valid), 8'd0);
    checkOutput({tag, " idle busy"}, 8'(busy), 8'd0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("reset rsp_valid", 8'(rsp_valid), 8'd0);
    checkOutput("reset busy", 8'(busy), 8'd0);
    checkOutput("reset rsp_y", 8'(rsp_y), 8'd0);
    checkOutput("reset rsp_id", 8'(rsp_id), 8'd0);
    checkOutput("reset flags", 8'({rsp_c, rsp_z, rsp_n}), 8'd0);
    rst = 1'b0;
    @(negedge clk);

    runOp(1'b0, 4'd7,  4'd9, 4'd0,  4'd0,  1'b1, 1'b1, 1'b0, "add 7+9");
    runOp(1'b1, 4'd3,  4'd5, 4'd1,  4'd14, 1'b1, 1'b0, 1'b1, "sub 3-5");
    runOp(1'b0, 4'd9,  4'd3, 4'd1,  4'd6,  1'b0, 1'b0, 1'b0, "sub 9-3");
    runOp(1'b0, 4'd3,  4'd4, 4'd6,  4'd0,  1'b0, 1'b1, 1'b0, "shl oob");
    runOp(1'b1, 4'd12, 4'd2, 4'd7,  4'd3,  1'b0, 1'b0, 1'b0, "shr 12>>2");
    runOp(1'b0, 4'd5,  4'd3, 4'd12, 4'd0,  1'b0, 1'b0, 1'b0, "op12");
    runOp(1'b1, 4'd15, 4'd15, 4'd5, 4'd0,  1'b0, 1'b1, 1'b0, "nand");
    runOp(1'b0, 4'd12, 4'd10, 4'd2, 4'd8,  1'b0, 1'b0, 1'b0, "and");
    runOp(1'b1, 4'd5,  4'd5, 4'd9,  4'd15, 1'b0, 1'b0, 1'b0, "xnor");

    // Contention from reset: grants alternate 0,1,0,1 with accepts 3 cycles apart.
    doReset();
    applyStimulus(1'b1, 4'd1, 4'd2, 4'd0, 1'b1, 4'd4, 4'd1, 4'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      #1;
      checkOutput($sformatf("rr%0d req0_ready", i), 8'(req0_ready), 8'(i % 2 == 0));
      checkOutput($sformatf("rr%0d req1_ready", i), 8'(req1_ready), 8'(i % 2 == 1));
      @(negedge clk);
      checkOutput($sformatf("rr%0d exec busy", i), 8'(busy), 8'd1);
      @(negedge clk);
      checkOutput($sformatf("rr%0d rsp_id", i), 8'(rsp_id), 8'(i % 2));
      checkOutput($sformatf("rr%0d rsp_y", i), 8'(rsp_y), (i % 2 == 1) ? 8'd5 : 8'd3);
      @(negedge clk);
    end
    applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1);

    // Back-pressure: response held for several cycles while both requesters wait.
    applyStimulus(1'b1, 4'd12, 4'd10, 4'd8, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
    #1;
    checkOutput("bp req0_ready", 8'(req0_ready), 8'd1);
    @(negedge clk);
    applyStimulus(1'b1, 4'd12, 4'd10, 4'd8, 1'b1, 4'd3, 4'd3, 4'd0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput($sformatf("bp%0d rsp_valid", i), 8'(rsp_valid), 8'd1);
      checkOutput($sformatf("bp%0d rsp_y", i), 8'(rsp_y), 8'd6);
      checkOutput($sformatf("bp%0d rsp_id", i), 8'(rsp_id), 8'd0);
      checkOutput($sformatf("bp%0d readies", i), 8'({req0_ready, req1_ready}), 8'd0);
    end
    applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 4'd3, 4'd3, 4'd0, 1'b1);
    @(negedge clk);
    checkOutput("bp release rsp_valid", 8'(rsp_valid), 8'd0);
    checkOutput("bp release busy", 8'(busy), 8'd0);
    checkOutput("bp release req1_ready", 8'(req1_ready), 8'd1);
    applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1);

    // Reset mid-EXEC after a req0 grant; reset must restore req0 priority.
    applyStimulus(1'b1, 4'd2, 4'd2, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1);
    @(negedge clk);
    checkOutput("rstexec busy before", 8'(busy), 8'd1);
    rst = 1'b1;
    applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1);
    #1;
    checkOutput("rstexec busy", 8'(busy), 8'd0);
    checkOutput("rstexec rsp_valid", 8'(rsp_valid), 8'd0);
    checkOutput("rstexec rsp_y", 8'(rsp_y), 8'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b1, 4'd1, 4'd1, 4'd0, 1'b1, 4'd1, 4'd1, 4'd0, 1'b1);
    #1;
    checkOutput("post-reset req0_ready", 8'(req0_ready), 8'd1);
    checkOutput("post-reset req1_ready", 8'(req1_ready), 8'd0);
    applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
